sram_port_arbiter: RTL and testbench
====================================

// Module: sram_port_arbiter
// PURPOSE
//  Shares the single SRAM port between two requesters: the input pixel fetch
//  (read) and the output buffer write-back (write, incl. final done-flag write).
//  Sits between the Sobel datapath and the SRAM model.
//  Runs one access at a time. Each access holds the SRAM strobes for a fixed
//  number of cycles. Round-robin arbitration avoids starving either side.
// PARAMETERS
//  ADDR_W      32  SRAM address width
//  DATA_W      32  SRAM data width
//  ACCESS_CYC  2   cycles sram_ren/sram_wen held per access (>=1)
// PORTS
//  clk         in   1       system clock
//  n_rst       in   1       asynchronous active-low reset
//  rd_req      in   1       read request; level, held until rd_grant
//  rd_addr     in   ADDR_W  read address; stable while rd_req high
//  rd_grant    out  1       1-cycle pulse: read accepted, rd_req may drop
//  rd_valid    out  1       1-cycle pulse: rd_data valid
//  rd_data     out  DATA_W  registered read data
//  wr_req      in   1       write request; level, held until wr_grant
//  wr_addr     in   ADDR_W  write address; stable while wr_req high
//  wr_data     in   DATA_W  write data; stable while wr_req high
//  wr_grant    out  1       1-cycle pulse: write accepted
//  wr_done     out  1       1-cycle pulse: write committed to SRAM
//  sram_addr   out  ADDR_W  SRAM address
//  sram_wdata  out  DATA_W  SRAM write data
//  sram_rdata  in   DATA_W  SRAM read data, valid in last access cycle
//  sram_ren    out  1       SRAM read strobe
//  sram_wen    out  1       SRAM write strobe
//  busy        out  1       high whenever state != IDLE
// BEHAVIOUR
//  Reset: state=IDLE, last=WR (first tie goes to read). All outputs 0:
//   strobes, grants, valid, done, busy, sram_addr, sram_wdata, rd_data.
//  FSM states: IDLE, READ, WRITE, TURN.
//   IDLE: sample rd_req/wr_req at the clock edge.
//    Only one asserted: go to its state.
//    Both asserted: grant the side not equal to last.
//   Entering READ/WRITE:
//    Latch addr (and wdata) into the sram_* registers.
//    Pulse rd_grant/wr_grant in the first cycle of the state.
//    Update last. Clear the access counter.
//   READ/WRITE: strobe held exactly ACCESS_CYC cycles; counter increments.
//   Last READ cycle: capture sram_rdata into rd_data. Go to TURN.
//   Last WRITE cycle: go to TURN.
//   TURN: one cycle, strobes low. Pulse rd_valid (after a read) or wr_done
//    (after a write). Go to IDLE.
//  Latency, req high in IDLE at edge k:
//   grant in cycle k+1; strobes in cycles k+1..k+ACCESS_CYC.
//   rd_valid/wr_done in cycle k+ACCESS_CYC+1.
//   Next grant no earlier than k+ACCESS_CYC+3.
//  Requests arriving while busy wait, because grants are issued only from IDLE.
//  Requests already held in IDLE compete normally.
//  sram_ren and sram_wen are never high together. Strobes are 0 in IDLE/TURN.
//  sram_addr/sram_wdata hold their last value outside an access.
//  Requester drops req after grant: ignored; the access completes.
//  Requester re-asserts req the cycle after grant: treated as a new request.
//  Reset mid-access:
//   Strobes drop asynchronously; the in-flight access is discarded.
//   No rd_valid/wr_done is emitted. Requesters reissue.
//  ACCESS_CYC=1: single strobe cycle, same TURN rule.
// STRUCTURE
//  Package sobel_mem_pkg:
//   arb_state_t {IDLE,READ,WRITE,TURN}
//   req_src_t {SRC_RD,SRC_WR}
//   SRAM_ADDR_W/SRAM_DATA_W constants (shared with outputBuffer).
//  Access counter: instantiate flex_counter (width $clog2(ACCESS_CYC+1),
//   rollover_val ACCESS_CYC, clear on state entry). Rollover flag marks the
//   last access cycle.
//  Remainder: state register, next-state/arbitration comb, datapath registers.
// TESTING (ACCESS_CYC=2)
//  1. Reset, then rd_req with rd_addr=0x100, sram_rdata=0xDEADBEEF
//     -> rd_grant at +1; sram_ren high 2 cycles with sram_addr=0x100;
//        rd_valid at +3 with rd_data=0xDEADBEEF.
//  2. wr_req with wr_addr=0x2A0, wr_data=0xFFFF0000
//     -> sram_wen 2 cycles with matching addr/wdata; wr_done at +3; ren stays 0.
//  3. rd_req and wr_req both held from reset
//     -> grant order R,W,R,W; gap between grants = 4 cycles.
//  4. wr_req held continuously, rd_req asserted mid-write
//     -> read granted next; write starves never more than one access.
//  5. n_rst low during the 2nd strobe cycle
//     -> strobes 0 immediately; no rd_valid; busy=0; the re-issued request
//        completes normally.
//  6. Assertion, all tests:
//     !(sram_ren && sram_wen); grants one-hot; busy==(state!=IDLE).

Source files
------------

// File: rtl/sobel_mem_pkg.sv
// Types and widths shared by the SRAM-side blocks of the Sobel engine.
// The read/write arbiter and the output buffer both import this package.
package sobel_mem_pkg;
  localparam int SRAM_ADDR_W = 32;
  localparam int SRAM_DATA_W = 32;

  typedef enum logic [1:0] {IDLE, READ, WRITE, TURN} arb_state_t;
  typedef enum logic {SRC_RD, SRC_WR} req_src_t;
endpackage

// File: rtl/flex_counter.sv
// Clearable up-counter with programmable rollover value.
// rollover_flag is high in the enabled cycle whose increment reaches rollover_val.
module flex_counter #(
  parameter int NUM_CNT_BITS = 4
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    clear,
  input  logic                    count_enable,
  input  logic [NUM_CNT_BITS-1:0] rollover_val,
  output logic [NUM_CNT_BITS-1:0] count_out,
  output logic                    rollover_flag
);
  logic [NUM_CNT_BITS-1:0] count_q, count_d;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) count_q <= '0;
    else        count_q <= count_d;
  end

  always_comb begin
    count_d = count_q;
    if (clear)
      count_d = '0;
    else if (count_enable)
      count_d = (count_q == rollover_val) ? NUM_CNT_BITS'(1) : count_q + NUM_CNT_BITS'(1);
  end

  assign count_out     = count_q;
  assign rollover_flag = count_enable && !clear && ((count_q + NUM_CNT_BITS'(1)) == rollover_val);
endmodule

// File: rtl/sram_port_arbiter.sv
// Round-robin arbiter sharing one SRAM port between the pixel fetch (read)
// and the output write-back (write); one fixed-length access at a time.
module sram_port_arbiter
  import sobel_mem_pkg::*;
#(
  parameter int ADDR_W     = SRAM_ADDR_W,
  parameter int DATA_W     = SRAM_DATA_W,
  parameter int ACCESS_CYC = 2
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_grant,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_grant,
  output logic              wr_done,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata,
  output logic              sram_ren,
  output logic              sram_wen,
  output logic              busy
);
  localparam int CNT_W = $clog2(ACCESS_CYC + 1);

  arb_state_t        state_q, state_d;
  req_src_t          last_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic [CNT_W-1:0]  cnt;
  logic              cnt_last;
  logic              cnt_clear;
  logic              in_access;

  assign in_access = (state_q == READ) || (state_q == WRITE);
  assign cnt_clear = (state_q == IDLE) && (state_d != IDLE);

  flex_counter #(.NUM_CNT_BITS(CNT_W)) u_access_cnt (
    .clk          (clk),
    .n_rst        (n_rst),
    .clear        (cnt_clear),
    .count_enable (in_access),
    .rollover_val (CNT_W'(ACCESS_CYC)),
    .count_out    (cnt),
    .rollover_flag(cnt_last)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // On a tie the side that was not served last wins.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (rd_req && (!wr_req || last_q == SRC_WR)) state_d = READ;
        else if (wr_req)                             state_d = WRITE;
      end
      READ, WRITE: if (cnt_last) state_d = TURN;
      TURN:        state_d = IDLE;
      default:     state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      last_q  <= SRC_WR;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      if (state_q == IDLE && state_d == READ) begin
        last_q <= SRC_RD;
        addr_q <= rd_addr;
      end else if (state_q == IDLE && state_d == WRITE) begin
        last_q  <= SRC_WR;
        addr_q  <= wr_addr;
        wdata_q <= wr_data;
      end
      if (state_q == READ && cnt_last) rdata_q <= sram_rdata;
    end
  end

  // Strobes and pulses decode straight from registered state so reset clears them at once.
  assign sram_ren   = (state_q == READ);
  assign sram_wen   = (state_q == WRITE);
  assign rd_grant   = (state_q == READ)  && (cnt == '0);
  assign wr_grant   = (state_q == WRITE) && (cnt == '0);
  assign rd_valid   = (state_q == TURN) && (last_q == SRC_RD);
  assign wr_done    = (state_q == TURN) && (last_q == SRC_WR);
  assign busy       = (state_q != IDLE);
  assign sram_addr  = addr_q;
  assign sram_wdata = wdata_q;
  assign rd_data    = rdata_q;
endmodule

// File: tb/tb_sram_port_arbiter.sv
// Self-checking bench for sram_port_arbiter: directed scenarios with literal
// expectations plus random request traffic checked against a timeline model.
module tb_sram_port_arbiter;
  localparam int AC = 2;

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic        rd_req = 1'b0, wr_req = 1'b0;
  logic [31:0] rd_addr = '0, wr_addr = '0, wr_data = '0, sram_rdata = '0;
  logic        rd_grant, rd_valid, wr_grant, wr_done, sram_ren, sram_wen, busy;
  logic [31:0] rd_data, sram_addr, sram_wdata;

  sram_port_arbiter #(.ADDR_W(32), .DATA_W(32), .ACCESS_CYC(AC)) dut (
    .clk(clk), .n_rst(n_rst),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_grant(rd_grant), .rd_valid(rd_valid), .rd_data(rd_data),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_grant(wr_grant), .wr_done(wr_done),
    .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
    .sram_ren(sram_ren), .sram_wen(sram_wen), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_asserts = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_asserts++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Timeline model: an access granted in cycle s strobes s..s+AC-1, reports in s+AC,
  // and the port is free again from s+AC+1 onward.
  int          cyc = 0;
  bit          m_active = 0;
  bit          m_src = 0;       // 0 = read, 1 = write
  bit          m_last = 1;
  int          m_start = 0;
  logic [31:0] m_addr = '0, m_wdata = '0, m_rdata = '0;

  always @(posedge clk) begin
    cyc++;
    if (!n_rst) begin
      m_active = 0; m_last = 1; m_addr = '0; m_wdata = '0; m_rdata = '0;
    end else begin
      if (m_active && m_src == 0 && cyc - 1 == m_start + AC - 1) m_rdata = sram_rdata;
      if (!(m_active && cyc - 1 <= m_start + AC)) begin
        if (rd_req && (!wr_req || m_last == 1)) begin
          m_active = 1; m_src = 0; m_start = cyc; m_last = 0; m_addr = rd_addr;
        end else if (wr_req) begin
          m_active = 1; m_src = 1; m_start = cyc; m_last = 1; m_addr = wr_addr; m_wdata = wr_data;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (n_rst) begin
      bit strobing, reporting, first;
      strobing  = m_active && cyc >= m_start && cyc <= m_start + AC - 1;
      reporting = m_active && cyc == m_start + AC;
      first     = m_active && cyc == m_start;
      check("ren",      sram_ren,   strobing && m_src == 0);
      check("wen",      sram_wen,   strobing && m_src == 1);
      check("rd_grant", rd_grant,   first && m_src == 0);
      check("wr_grant", wr_grant,   first && m_src == 1);
      check("rd_valid", rd_valid,   reporting && m_src == 0);
      check("wr_done",  wr_done,    reporting && m_src == 1);
      check("busy",     busy,       strobing || reporting);
      check("addr",     sram_addr,  m_addr);
      check("wdata",    sram_wdata, m_wdata);
      check("rd_data",  rd_data,    m_rdata);
      check("strobe_excl", sram_ren && sram_wen, 1'b0);
      check("grant_excl",  rd_grant && wr_grant, 1'b0);
    end
  end

  task automatic wait_grant(output int src, output int at);
    src = -1; at = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rd_grant) begin src = 0; at = cyc; return; end
      if (wr_grant) begin src = 1; at = cyc; return; end
    end
    n_asserts++; n_fail++;
    $display("FAIL grant_timeout: no grant within 20 cycles (t=%0t)", $time);
  endtask

  int g_src [4];
  int g_at  [4];
  int s, a;

  initial begin
    // Reset values
    repeat (3) @(negedge clk);
    check("rst_ren", sram_ren, 0); check("rst_wen", sram_wen, 0); check("rst_busy", busy, 0);
    check("rst_addr", sram_addr, 0); check("rst_wdata", sram_wdata, 0); check("rst_rdata", rd_data, 0);
    n_rst = 1'b1;

    // Single read
    @(negedge clk); rd_req = 1; rd_addr = 32'h100; sram_rdata = 32'hDEADBEEF;
    @(negedge clk); check("t1_grant", rd_grant, 1); check("t1_ren0", sram_ren, 1);
    check("t1_addr", sram_addr, 32'h100); rd_req = 0;
    @(negedge clk); check("t1_ren1", sram_ren, 1); check("t1_grant_off", rd_grant, 0);
    @(negedge clk); check("t1_ren_off", sram_ren, 0); check("t1_valid", rd_valid, 1);
    check("t1_data", rd_data, 32'hDEADBEEF);
    @(negedge clk); check("t1_idle", busy, 0);

    // Single write
    wr_req = 1; wr_addr = 32'h2A0; wr_data = 32'hFFFF0000;
    @(negedge clk); check("t2_grant", wr_grant, 1); check("t2_wen0", sram_wen, 1);
    check("t2_addr", sram_addr, 32'h2A0); check("t2_wdata", sram_wdata, 32'hFFFF0000);
    check("t2_ren", sram_ren, 0); wr_req = 0;
    @(negedge clk); check("t2_wen1", sram_wen, 1);
    @(negedge clk); check("t2_done", wr_done, 1); check("t2_wen_off", sram_wen, 0);
    @(negedge clk); check("t2_idle", busy, 0);

    // Both held from reset: R,W,R,W with 4-cycle spacing
    n_rst = 0; rd_req = 1; wr_req = 1; rd_addr = 32'h400; wr_addr = 32'h500; wr_data = 32'h55;
    @(negedge clk); n_rst = 1;
    for (int i = 0; i < 4; i++) begin wait_grant(s, a); g_src[i] = s; g_at[i] = a; end
    check("t3_order0", g_src[0], 0); check("t3_order1", g_src[1], 1);
    check("t3_order2", g_src[2], 0); check("t3_order3", g_src[3], 1);
    for (int i = 1; i < 4; i++) check("t3_gap", g_at[i] - g_at[i-1], 4);
    rd_req = 0;

    // Write held continuously, read arrives mid-write
    wait_grant(s, a); check("t4_w_first", s, 1);
    rd_req = 1; rd_addr = 32'h600;
    wait_grant(s, a); check("t4_read_next", s, 0); rd_req = 0;
    wait_grant(s, a); check("t4_write_after", s, 1); wr_req = 0;
    repeat (4) @(negedge clk);

    // Reset during the 2nd strobe cycle of a read; reissued read completes
    rd_req = 1; rd_addr = 32'h340; sram_rdata = 32'h12345678;
    wait_grant(s, a); check("t5_grant", s, 0);
    @(negedge clk); check("t5_ren_pre", sram_ren, 1);
    #1 n_rst = 0;
    #1 check("t5_ren_rst", sram_ren, 0); check("t5_busy_rst", busy, 0);
    check("t5_valid_rst", rd_valid, 0);
    @(negedge clk); check("t5_valid_hold", rd_valid, 0);
    @(negedge clk); n_rst = 1;
    wait_grant(s, a); check("t5_regrant", s, 0); rd_req = 0;
    @(negedge clk);
    @(negedge clk); check("t5_valid", rd_valid, 1); check("t5_data", rd_data, 32'h12345678);

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (rd_req && rd_grant) begin rd_req = ($urandom_range(0, 3) == 0); rd_addr = $urandom; end
      else if (!rd_req && $urandom_range(0, 2) == 0) begin rd_req = 1; rd_addr = $urandom; end
      if (wr_req && wr_grant) begin
        wr_req = ($urandom_range(0, 3) == 0); wr_addr = $urandom; wr_data = $urandom;
      end else if (!wr_req && $urandom_range(0, 2) == 0) begin
        wr_req = 1; wr_addr = $urandom; wr_data = $urandom;
      end
      sram_rdata = $urandom;
      if ($urandom_range(0, 499) == 0) begin
        #2 n_rst = 0;
        #1 check("rnd_rst_ren", sram_ren, 0); check("rnd_rst_wen", sram_wen, 0);
        check("rnd_rst_busy", busy, 0);
        @(negedge clk); @(negedge clk); n_rst = 1;
      end
    end
    rd_req = 0; wr_req = 0;
    repeat (6) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end
endmodule
